// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: RV32I opcodes, instruction class
// codes and the opcode-to-class lookup used by the decoder.
package decode_stage_pkg;

  typedef logic [3:0] class_t;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] R_OPCODE     = 7'b0110011;
  localparam logic [6:0] I_OPCODE     = 7'b0010011;
  localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
  localparam logic [6:0] S_OPCODE     = 7'b0100011;
  localparam logic [6:0] B_OPCODE     = 7'b1100011;
  localparam logic [6:0] JAL_OPCODE   = 7'b1101111;
  localparam logic [6:0] JALR_OPCODE  = 7'b1100111;
  localparam logic [6:0] LUI_OPCODE   = 7'b0110111;
  localparam logic [6:0] AUIPC_OPCODE = 7'b0010111;

  // Class codes; NOP is zero so a freshly reset stage presents a NOP
  localparam class_t CLASS_NOP     = 4'd0;
  localparam class_t CLASS_R       = 4'd1;
  localparam class_t CLASS_I       = 4'd2;
  localparam class_t CLASS_LOAD    = 4'd3;
  localparam class_t CLASS_S       = 4'd4;
  localparam class_t CLASS_B       = 4'd5;
  localparam class_t CLASS_JAL     = 4'd6;
  localparam class_t CLASS_JALR    = 4'd7;
  localparam class_t CLASS_LUI     = 4'd8;
  localparam class_t CLASS_AUIPC   = 4'd9;
  localparam class_t CLASS_ILLEGAL = 4'd15;

  // Unknown opcodes map to CLASS_NOP; the trap build remaps them afterwards
  function automatic class_t opcode_class(input logic [6:0] opcode);
    case (opcode)
      R_OPCODE:     return CLASS_R;
      I_OPCODE:     return CLASS_I;
      LOAD_OPCODE:  return CLASS_LOAD;
      S_OPCODE:     return CLASS_S;
      B_OPCODE:     return CLASS_B;
      JAL_OPCODE:   return CLASS_JAL;
      JALR_OPCODE:  return CLASS_JALR;
      LUI_OPCODE:   return CLASS_LUI;
      AUIPC_OPCODE: return CLASS_AUIPC;
      default:      return CLASS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundle for decode_stage: fetch-side handshake, register file read
// port, flush, and execute-side handshake with the decoded head entry.
// The stage uses the slave modport; its environment drives the master.
interface decode_stage_if #(
  parameter int OPD_LENGTH = 16,
  parameter int REG_WIDTH  = 16
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [OPD_LENGTH-1:0] pc;
  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic [REG_WIDTH-1:0]  rs1_data;
  logic [REG_WIDTH-1:0]  rs2_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4:0]            rd_addr;
  logic [3:0]            instr_class;
  logic [OPD_LENGTH-1:0] opd1;
  logic [OPD_LENGTH-1:0] opd2;
  logic [OPD_LENGTH-1:0] opd3;
  logic [OPD_LENGTH-1:0] opd4;

  modport slave (
    input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, rd_addr, instr_class,
           opd1, opd2, opd3, opd4
  );

  modport master (
    output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, rd_addr, instr_class,
           opd1, opd2, opd3, opd4
  );
endinterface

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate extraction. Each immediate is built as a
// sign-extended 32-bit value, then resized to OPD_LENGTH (sign-extended if
// wider, truncated if narrower). The opcode bits are not needed here.
module decode_imm_gen #(
  parameter int OPD_LENGTH = 16
) (
  input  logic [31:7]           instr,
  output logic [OPD_LENGTH-1:0] imm_i,
  output logic [OPD_LENGTH-1:0] imm_s,
  output logic [OPD_LENGTH-1:0] imm_b,
  output logic [OPD_LENGTH-1:0] imm_j,
  output logic [OPD_LENGTH-1:0] imm_u
);
  logic signed [31:0] i32, s32, b32, j32, u32;

  assign i32 = {{20{instr[31]}}, instr[31:20]};
  assign s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // U-type is already the upper 20 bits shifted left by 12
  assign u32 = {instr[31:12], 12'b0};

  assign imm_i = OPD_LENGTH'(i32);
  assign imm_s = OPD_LENGTH'(s32);
  assign imm_b = OPD_LENGTH'(b32);
  assign imm_j = OPD_LENGTH'(j32);
  assign imm_u = OPD_LENGTH'(u32);
endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes the fetched word into a class code,
// destination register and four operands, then captures the result in a
// DEPTH-entry circular queue with valid/ready on both sides.
// Optional build macro: ILLEGAL_TRAP_EN -- unknown opcodes become
// CLASS_ILLEGAL carrying the raw instruction bits in opd3 instead of a NOP.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int OPD_LENGTH = 16,
  parameter int REG_WIDTH  = 16,
  parameter int DEPTH      = 2
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------- decode ----------------
  logic [OPD_LENGTH-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [OPD_LENGTH-1:0] rs1_ext, rs2_ext, rs2_raw;
  class_t                dec_class;
  logic [4:0]            dec_rd;
  logic [OPD_LENGTH-1:0] dec_opd1, dec_opd2, dec_opd3;

  decode_imm_gen #(.OPD_LENGTH(OPD_LENGTH)) imm_gen (
    .instr (bus.instr[31:7]),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_j (imm_j),
    .imm_u (imm_u)
  );

  assign bus.rs1_addr = bus.instr[19:15];
  assign bus.rs2_addr = bus.instr[24:20];

  // Source operands are treated as signed values; store data is raw bits
  assign rs1_ext = OPD_LENGTH'($signed(bus.rs1_data));
  assign rs2_ext = OPD_LENGTH'($signed(bus.rs2_data));
  assign rs2_raw = OPD_LENGTH'(bus.rs2_data);

  // Class/operand mux for the word presented by fetch
  always_comb begin
    dec_class = opcode_class(bus.instr[6:0]);
    dec_rd    = bus.instr[11:7];
    dec_opd1  = '0;
    dec_opd2  = '0;
    dec_opd3  = '0;
    case (dec_class)
      CLASS_R: begin
        dec_opd1 = rs1_ext;
        dec_opd2 = rs2_ext;
      end
      CLASS_I, CLASS_LOAD, CLASS_JALR: begin
        dec_opd1 = rs1_ext;
        dec_opd2 = imm_i;
      end
      CLASS_S: begin
        dec_rd   = '0;
        dec_opd1 = rs1_ext;
        dec_opd2 = imm_s;
        dec_opd3 = rs2_raw;
      end
      CLASS_B: begin
        dec_rd   = '0;
        dec_opd1 = rs1_ext;
        dec_opd2 = rs2_ext;
        dec_opd3 = imm_b;
      end
      CLASS_JAL: begin
        dec_opd1 = bus.pc;
        dec_opd2 = imm_j;
      end
      CLASS_LUI: begin
        dec_opd2 = imm_u;
      end
      CLASS_AUIPC: begin
        dec_opd1 = bus.pc;
        dec_opd2 = imm_u;
      end
      default: begin
        dec_rd = '0;
`ifdef ILLEGAL_TRAP_EN
        dec_class = CLASS_ILLEGAL;
        dec_opd3  = OPD_LENGTH'(bus.instr);
`endif
      end
    endcase
  end

  // ---------------- queue ----------------
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  full, empty, push, pop;

  logic [4:0]            q_rd    [DEPTH];
  class_t                q_class [DEPTH];
  logic [OPD_LENGTH-1:0] q_opd1  [DEPTH];
  logic [OPD_LENGTH-1:0] q_opd2  [DEPTH];
  logic [OPD_LENGTH-1:0] q_opd3  [DEPTH];
  logic [OPD_LENGTH-1:0] q_opd4  [DEPTH];

  logic [4:0]            last_rd_reg;
  class_t                last_class_reg;
  logic [OPD_LENGTH-1:0] last_opd1_reg, last_opd2_reg, last_opd3_reg, last_opd4_reg;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  // No pass-through when full: a same-cycle pop does not open a slot
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push = bus.in_valid && !full && !bus.flush;
  assign pop  = !empty && bus.out_ready && !bus.flush;

  // Pointer and occupancy bookkeeping; flush empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Capture the decoded word into the slot addressed by the write pointer
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          q_rd[gi]    <= dec_rd;
          q_class[gi] <= dec_class;
          q_opd1[gi]  <= dec_opd1;
          q_opd2[gi]  <= dec_opd2;
          q_opd3[gi]  <= dec_opd3;
          q_opd4[gi]  <= bus.pc;
        end
      end
    end
  endgenerate

  // Remember the entry being consumed so an empty queue keeps showing it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rd_reg    <= '0;
      last_class_reg <= CLASS_NOP;
      last_opd1_reg  <= '0;
      last_opd2_reg  <= '0;
      last_opd3_reg  <= '0;
      last_opd4_reg  <= '0;
    end else if (pop) begin
      last_rd_reg    <= q_rd[rd_ptr_reg];
      last_class_reg <= q_class[rd_ptr_reg];
      last_opd1_reg  <= q_opd1[rd_ptr_reg];
      last_opd2_reg  <= q_opd2[rd_ptr_reg];
      last_opd3_reg  <= q_opd3[rd_ptr_reg];
      last_opd4_reg  <= q_opd4[rd_ptr_reg];
    end
  end

  assign bus.rd_addr     = empty ? last_rd_reg    : q_rd[rd_ptr_reg];
  assign bus.instr_class = empty ? last_class_reg : q_class[rd_ptr_reg];
  assign bus.opd1        = empty ? last_opd1_reg  : q_opd1[rd_ptr_reg];
  assign bus.opd2        = empty ? last_opd2_reg  : q_opd2[rd_ptr_reg];
  assign bus.opd3        = empty ? last_opd3_reg  : q_opd3[rd_ptr_reg];
  assign bus.opd4        = empty ? last_opd4_reg  : q_opd4[rd_ptr_reg];
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (DEPTH=2, 16-bit operands). Expected
// decodes are pushed to a scoreboard when the stage accepts a word and are
// compared field by field when execute consumes the head entry.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic [4:0]  rd;
    logic [3:0]  cls;
    logic [15:0] o1;
    logic [15:0] o2;
    logic [15:0] o3;
    logic [15:0] o4;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pops   = 0;
  exp_t sb[$];

  decode_stage_if #(.OPD_LENGTH(16), .REG_WIDTH(16)) bus ();

  decode_stage #(.OPD_LENGTH(16), .REG_WIDTH(16), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [4:0] rd, input logic [3:0] cls,
                              input logic [15:0] o1, input logic [15:0] o2,
                              input logic [15:0] o3, input logic [15:0] o4);
    exp_t e;
    e.rd = rd; e.cls = cls; e.o1 = o1; e.o2 = o2; e.o3 = o3; e.o4 = o4;
    return e;
  endfunction

  // Present a word until the stage accepts it, then log the expected decode
  task automatic send(input logic [31:0] i, input logic [15:0] p,
                      input logic [15:0] r1, input logic [15:0] r2, input exp_t e);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.instr    = i;
    bus.pc       = p;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    for (int c = 0; c < 100 && !done; c++) begin
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1;
      end
      @(negedge clk);
    end
    if (!done) check("send_accept", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Compare the head against the scoreboard whenever execute consumes it
  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pops++;
        $display("pop %0d: class=%0d rd=%0d opd1=%h opd2=%h opd3=%h opd4=%h",
                 n_pops, bus.instr_class, bus.rd_addr, bus.opd1, bus.opd2, bus.opd3, bus.opd4);
        check("rd_addr",     32'(bus.rd_addr),     32'(e.rd));
        check("instr_class", 32'(bus.instr_class), 32'(e.cls));
        check("opd1",        32'(bus.opd1),        32'(e.o1));
        check("opd2",        32'(bus.opd2),        32'(e.o2));
        check("opd3",        32'(bus.opd3),        32'(e.o3));
        check("opd4",        32'(bus.opd4),        32'(e.o4));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] add_i, sw_i, bge_i, jal_i, lui_i, addi_i, lw_i, jalr_i, auipc_i, unk_i;
    exp_t unk0_e, unk1_e;

    add_i   = {7'd0, 5'd4, 5'd3, 3'b000, 5'd2, 7'b0110011};              // ADD x2,x3,x4
    sw_i    = {7'd0, 5'd4, 5'd3, 3'b010, 5'd12, 7'b0100011};             // SW x4,12(x3)
    bge_i   = {1'b0, 6'd0, 5'd4, 5'd3, 3'b101, 4'd6, 1'b0, 7'b1100011};  // BGE x3,x4,12
    jal_i   = {1'b0, 10'd40, 1'b0, 8'd0, 5'd3, 7'b1101111};              // JAL x3,80
    lui_i   = {20'd2, 5'd10, 7'b0110111};                                // LUI x10,2
    addi_i  = {12'hFFF, 5'd2, 3'b000, 5'd1, 7'b0010011};                 // ADDI x1,x2,-1
    lw_i    = {12'hFFC, 5'd8, 3'b010, 5'd7, 7'b0000011};                 // LW x7,-4(x8)
    jalr_i  = {12'd8, 5'd5, 3'b000, 5'd1, 7'b1100111};                   // JALR x1,8(x5)
    auipc_i = {20'hFFFFF, 5'd5, 7'b0010111};                             // AUIPC x5,0xFFFFF
    unk_i   = 32'h1234_567F;
`ifdef ILLEGAL_TRAP_EN
    unk0_e = mk(5'd0, CLASS_ILLEGAL, 16'h0, 16'h0, 16'h0000, 16'h0200);
    unk1_e = mk(5'd0, CLASS_ILLEGAL, 16'h0, 16'h0, 16'h567F, 16'h0204);
`else
    unk0_e = mk(5'd0, CLASS_NOP, 16'h0, 16'h0, 16'h0, 16'h0200);
    unk1_e = mk(5'd0, CLASS_NOP, 16'h0, 16'h0, 16'h0, 16'h0204);
`endif

    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_rd_addr",   32'(bus.rd_addr),       32'd0);
    check("rst_class",     32'(bus.instr_class),   32'd0);
    check("rst_opd1",      32'(bus.opd1),          32'd0);
    check("rst_opd4",      32'(bus.opd4),          32'd0);

    // Decode coverage, streamed back to back with execute always ready
    send(add_i, 16'h0010, 16'd9, 16'd13, mk(5'd2, CLASS_R, 16'd9, 16'd13, 16'd0, 16'h0010));
    check("rs1_addr", 32'(bus.rs1_addr), 32'd3);
    check("rs2_addr", 32'(bus.rs2_addr), 32'd4);
    check("latency_out_valid", {31'b0, bus.out_valid}, 32'd1);
    send(sw_i,    16'h0014, 16'h0020, 16'h0005, mk(5'd0,  CLASS_S,     16'h0020, 16'd12,   16'd5,  16'h0014));
    send(bge_i,   16'h0018, 16'h0007, 16'hFFF0, mk(5'd0,  CLASS_B,     16'h0007, 16'hFFF0, 16'd12, 16'h0018));
    send(jal_i,   16'h0100, 16'h0001, 16'h0002, mk(5'd3,  CLASS_JAL,   16'h0100, 16'd80,   16'd0,  16'h0100));
    send(lui_i,   16'h0104, 16'h1111, 16'h2222, mk(5'd10, CLASS_LUI,   16'h0000, 16'h2000, 16'd0,  16'h0104));
    send(addi_i,  16'h0108, 16'h1234, 16'h0000, mk(5'd1,  CLASS_I,     16'h1234, 16'hFFFF, 16'd0,  16'h0108));
    send(lw_i,    16'h010C, 16'h0400, 16'h0000, mk(5'd7,  CLASS_LOAD,  16'h0400, 16'hFFFC, 16'd0,  16'h010C));
    send(jalr_i,  16'h0110, 16'h0800, 16'h0000, mk(5'd1,  CLASS_JALR,  16'h0800, 16'd8,    16'd0,  16'h0110));
    send(auipc_i, 16'h0040, 16'h0000, 16'h0000, mk(5'd5,  CLASS_AUIPC, 16'h0040, 16'hF000, 16'd0,  16'h0040));
    send(32'h0,   16'h0200, 16'h5555, 16'h6666, unk0_e);
    send(unk_i,   16'h0204, 16'h5555, 16'h6666, unk1_e);
    repeat (3) @(negedge clk);
    check("stream_drained", 32'(sb.size()), 32'd0);
    check("empty_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("hold_last_class", 32'(bus.instr_class), 32'(unk1_e.cls));
    check("hold_last_opd4",  32'(bus.opd4),        32'h0204);

    // Full queue: no acceptance, no pass-through, in-order drain
    bus.out_ready = 1'b0;
    send(add_i, 16'h0300, 16'd1, 16'd2, mk(5'd2, CLASS_R, 16'd1, 16'd2, 16'd0, 16'h0300));
    send(sw_i,  16'h0304, 16'd3, 16'd4, mk(5'd0, CLASS_S, 16'd3, 16'd12, 16'd4, 16'h0304));
    bus.in_valid = 1'b1; bus.instr = bge_i; bus.pc = 16'h0308;
    bus.rs1_data = 16'd5; bus.rs2_data = 16'd6;
    check("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    check("full_in_ready_hold", {31'b0, bus.in_ready}, 32'd0);
    check("full_out_valid",     {31'b0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    check("full_no_passthru", {31'b0, bus.in_ready}, 32'd0);
    send(bge_i, 16'h0308, 16'd5, 16'd6, mk(5'd0, CLASS_B, 16'd5, 16'd6, 16'd12, 16'h0308));
    repeat (3) @(negedge clk);
    check("full_drained", 32'(sb.size()), 32'd0);

    // Flush with two queued and a word offered
    bus.out_ready = 1'b0;
    send(add_i, 16'h0400, 16'd1, 16'd2, mk(5'd2, CLASS_R, 16'd1, 16'd2, 16'd0, 16'h0400));
    send(lui_i, 16'h0404, 16'd0, 16'd0, mk(5'd10, CLASS_LUI, 16'd0, 16'h2000, 16'd0, 16'h0404));
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.instr = add_i;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    check("flush2_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("flush2_in_ready",  {31'b0, bus.in_ready},  32'd1);
    @(negedge clk);
    check("flush2_stays_empty", {31'b0, bus.out_valid}, 32'd0);

    // Flush with one queued, where a push would otherwise be accepted
    send(jal_i, 16'h0500, 16'd0, 16'd0, mk(5'd3, CLASS_JAL, 16'h0500, 16'd80, 16'd0, 16'h0500));
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.instr = add_i;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    sb.delete();
    check("flush1_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("flush1_no_push", {31'b0, bus.out_valid}, 32'd0);

    // Asynchronous reset in the middle of filling
    send(add_i, 16'h0600, 16'd1, 16'd2, mk(5'd2, CLASS_R, 16'd1, 16'd2, 16'd0, 16'h0600));
    bus.in_valid = 1'b1; bus.instr = sw_i;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_mid_in_ready",  {31'b0, bus.in_ready},  32'd1);
    check("rst_mid_class",     32'(bus.instr_class),   32'd0);
    sb.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_stays_empty", {31'b0, bus.out_valid}, 32'd0);

    // Stage works normally after the reset
    bus.out_ready = 1'b1;
    send(addi_i, 16'h0700, 16'h0010, 16'd0, mk(5'd1, CLASS_I, 16'h0010, 16'hFFFF, 16'd0, 16'h0700));
    repeat (3) @(negedge clk);
    check("final_drained", 32'(sb.size()), 32'd0);
    check("pop_count", 32'(n_pops), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
